// File: rtl/apb_master.sv
// APB4 initiator: one single-beat core request at a time, carried through SETUP and ACCESS.
// Optional ACCESS-phase timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pwstrb,
  input  logic              pready,
  input  logic [31:0]       prdata,
  input  logic              pslverr,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both high; rsp_valid is a single-cycle pulse with no backpressure.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [3:0]          pwstrb_q, pwstrb_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  // Abort fires on the wait cycle that would bring the count up to TIMEOUT.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0]         cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pwstrb_d    = pwstrb_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // req_ready is low for the first IDLE cycle after reset, then held high.
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          paddr_d     = req_addr;
          pwrite_d    = req_write;
          pwdata_d    = req_wdata;
          pwstrb_d    = req_wstrb;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          req_ready_d = 1'b0;
          state_d     = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = 16'd0;
`endif
      end

      S_ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? 32'd0 : prdata;
          rsp_err_d   = pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end

      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        req_ready_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'd0;
      pwstrb_q    <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pwstrb_q    <= pwstrb_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pwstrb    = pwstrb_q;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: driver tasks, a wait-state slave model and
// a response scoreboard; build with APB_MASTER_TIMEOUT_EN to exercise the abort path.
module tb_apb_master;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = 16'd0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'd0;
  logic        pslverr = 1'b0;
  logic [1:0]  dbg_state;

  apb_master #(.ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pwstrb(pwstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  int          wait_n = 0;
  logic [31:0] rd_val = 32'd0;
  logic        err_val = 1'b0;
  int          acnt = 0;

  // Ready comes on ACCESS index wait_n; bus junk elsewhere must be ignored.
  always @(negedge clk) begin
    if (rst || !(psel && penable)) begin
      acnt    = 0;
      pready  = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
    end else begin
      if (acnt == wait_n) begin
        pready  = 1'b1;
        prdata  = rd_val;
        pslverr = err_val;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
      end
      acnt++;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_rdata_q[$];
  logic [31:0] exp_err_q[$];
  int          exp_lat_q[$];
  int          acc_cyc_q[$];
  logic [15:0] cur_addr = 16'd0;
  logic        cur_write = 1'b0;
  logic [31:0] cur_wdata = 32'd0;
  logic [3:0]  cur_wstrb = 4'd0;
  int          phase = 0;
  int          psel_len = 0;
  bit          b2b = 1'b0;
  int          prev_acc = -1;
  int          rsp_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
    end else begin
      if (psel) begin
        check_eq("paddr_stable", 32'(paddr), 32'(cur_addr));
        check_eq("pwrite_stable", 32'(pwrite), 32'(cur_write));
        check_eq("pwdata_stable", pwdata, cur_wdata);
        check_eq("pwstrb_stable", 32'(pwstrb), 32'(cur_wstrb));
        check_eq("penable_phase", 32'(penable), (phase > 0) ? 32'd1 : 32'd0);
        phase++;
      end else begin
        if (phase > 0) psel_len = phase;
        phase = 0;
        check_eq("penable_idle", 32'(penable), 32'd0);
      end

      if (rsp_valid) begin
        rsp_seen++;
        if (exp_rdata_q.size() == 0) begin
          check_eq("rsp_unexpected", 32'(exp_rdata_q.size()), 32'd1);
        end else begin
          logic [31:0] er, ee;
          int el, ac;
          er = exp_rdata_q.pop_front();
          ee = exp_err_q.pop_front();
          el = exp_lat_q.pop_front();
          ac = acc_cyc_q.pop_front();
          check_eq("rsp_rdata", rsp_rdata, er);
          check_eq("rsp_err", 32'(rsp_err), ee);
          check_eq("rsp_latency", 32'(cyc - ac), 32'(el));
          check_eq("psel_cycles", 32'(psel_len), 32'(el - 1));
        end
      end

      if (req_valid && req_ready) begin
        if (b2b && prev_acc >= 0) check_eq("b2b_gap", 32'(cyc - prev_acc), 32'd3);
        prev_acc = cyc;
        if (TO_EN && wait_n >= TO) begin
          exp_rdata_q.push_back(32'd0);
          exp_err_q.push_back(32'd1);
          exp_lat_q.push_back(2 + TO);
        end else begin
          exp_rdata_q.push_back(req_write ? 32'd0 : rd_val);
          exp_err_q.push_back(32'(err_val));
          exp_lat_q.push_back(3 + wait_n);
        end
        acc_cyc_q.push_back(cyc);
        cur_addr  = req_addr;
        cur_write = req_write;
        cur_wdata = req_wdata;
        cur_wstrb = req_wstrb;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_wstrb = s;
    req_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        check_eq("accept_timeout", 32'(req_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int bound);
    int n;
    n = 0;
    req_valid = 1'b0;
    while (exp_rdata_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("rsp_pending", 32'(exp_rdata_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rdy_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_eq("rdy_after_edge", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid();
    int n, seen;
    n = 0;
    while (!(psel && penable) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("reached_access", 32'(psel && penable), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_psel", 32'(psel), 32'd0);
    check_eq("rst_penable", 32'(penable), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_paddr", 32'(paddr), 32'd0);
    exp_rdata_q.delete();
    exp_err_q.delete();
    exp_lat_q.delete();
    acc_cyc_q.delete();
    req_valid = 1'b0;
    seen = rsp_seen;
    repeat (3) @(negedge clk);
    release_rst();
    repeat (3) @(negedge clk);
    check_eq("no_rsp_after_rst", 32'(rsp_seen), 32'(seen));
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int seen;
    logic w;

    repeat (2) @(negedge clk);
    check_eq("reset_psel", 32'(psel), 32'd0);
    check_eq("reset_penable", 32'(penable), 32'd0);
    check_eq("reset_paddr", 32'(paddr), 32'd0);
    check_eq("reset_pwrite", 32'(pwrite), 32'd0);
    check_eq("reset_pwdata", pwdata, 32'd0);
    check_eq("reset_pwstrb", 32'(pwstrb), 32'd0);
    check_eq("reset_req_ready", 32'(req_ready), 32'd0);
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("reset_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("reset_state", 32'(dbg_state), 32'd0);
    release_rst();

    // zero-wait write
    wait_n = 0; err_val = 1'b0; rd_val = 32'hCAFE_0001;
    send(16'h8000, 1'b1, 32'h1234_5678, 4'hF);
    wait_rsp(50);

    // read with two wait states
    wait_n = 2; rd_val = 32'hDEAD_BEEF;
    send(16'h0004, 1'b0, $urandom, 4'hF);
    wait_rsp(50);

    // slave error, then a clean read
    wait_n = 0; err_val = 1'b1;
    send(16'h0010, 1'b1, 32'hA5A5_5A5A, 4'h3);
    wait_rsp(50);
    err_val = 1'b0; rd_val = 32'h0BAD_F00D;
    send(16'h0014, 1'b0, 32'd0, 4'hF);
    wait_rsp(50);

    // back-to-back, req_valid held high across four requests
    wait_n = 0; err_val = 1'b0; rd_val = $urandom;
    b2b = 1'b1; prev_acc = -1;
    for (int i = 0; i < 4; i++) begin
      w = i[0];
      send(16'(16'h0100 + 16'(i * 4)), w, $urandom, w ? 4'(i + 1) : 4'hF);
    end
    wait_rsp(50);
    b2b = 1'b0;

    // randomised transfers
    for (int i = 0; i < 8; i++) begin
      wait_n  = $urandom_range(0, 3);
      err_val = 1'($urandom_range(0, 1));
      rd_val  = $urandom;
      w       = 1'($urandom_range(0, 1));
      send(16'($urandom), w, $urandom, w ? 4'($urandom_range(0, 15)) : 4'hF);
      wait_rsp(50);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // ready on the last permitted cycle completes normally
    wait_n = TO - 1; err_val = 1'b0; rd_val = 32'h1357_9BDF;
    send(16'h0200, 1'b0, 32'd0, 4'hF);
    wait_rsp(50);
    // pready held low: abort
    wait_n = 5000; rd_val = 32'hFFFF_FFFF;
    send(16'h0204, 1'b0, 32'd0, 4'hF);
    wait_rsp(50);
    check_eq("psel_after_abort", 32'(psel), 32'd0);
    wait_n = 5000;
    send(16'h0208, 1'b0, 32'd0, 4'hF);
    reset_mid();
`else
    // pready held low: no timeout, still waiting after 1000 cycles
    wait_n = 5000; rd_val = 32'hFFFF_FFFF;
    seen = rsp_seen;
    send(16'h0204, 1'b0, 32'd0, 4'hF);
    req_valid = 1'b0;
    repeat (1000) @(negedge clk);
    check_eq("stall_psel", 32'(psel), 32'd1);
    check_eq("stall_penable", 32'(penable), 32'd1);
    check_eq("stall_state", 32'(dbg_state), 32'd2);
    check_eq("stall_no_rsp", 32'(rsp_seen), 32'(seen));
    reset_mid();
`endif

    // clean transfer after reset recovery
    wait_n = 1; err_val = 1'b0; rd_val = 32'h2468_ACE0;
    send(16'h0300, 1'b0, 32'd0, 4'hF);
    wait_rsp(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
